// File: rtl/alu_dsub_serial.sv
// Digit-serial packed-BCD subtractor: one decimal digit per RUN cycle, LSD first.
// Result flags are registered at DONE entry and hold until the next completion or reset.
module alu_dsub_serial (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        carry_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        carry_out,
   output logic        zero,
   output logic        invalid
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  r_state;
   logic [1:0]  r_cnt;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic        r_borrow;
   logic [15:0] r_work;
   logic        r_inv;
   logic [15:0] r_result;
   logic        r_cout;
   logic        r_zero;
   logic        r_invalid;

   logic [3:0]  w_ai;
   logic [3:0]  w_bi;
   logic [4:0]  w_d;
   logic [4:0]  w_d10;
   logic [3:0]  w_dig;
   logic        w_brw_nxt;
   logic        w_inv_nxt;
   logic [15:0] w_work_nxt;

   assign w_ai      = r_a[{r_cnt, 2'b00} +: 4];
   assign w_bi      = r_b[{r_cnt, 2'b00} +: 4];
   // 5-bit signed difference; bit 4 set means the digit went negative
   assign w_d       = {1'b0, w_ai} - {1'b0, w_bi} - {4'b0000, r_borrow};
   assign w_d10     = w_d + 5'd10;
   assign w_brw_nxt = w_d[4];
   assign w_dig     = w_brw_nxt ? w_d10[3:0] : w_d[3:0];
   assign w_inv_nxt = r_inv | (w_ai > 4'd9) | (w_bi > 4'd9);

   always_comb begin
      w_work_nxt = r_work;
      w_work_nxt[{r_cnt, 2'b00} +: 4] = w_dig;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= 2'd0;
         r_a       <= 16'h0000;
         r_b       <= 16'h0000;
         r_borrow  <= 1'b0;
         r_work    <= 16'h0000;
         r_inv     <= 1'b0;
         r_result  <= 16'h0000;
         r_cout    <= 1'b0;
         r_zero    <= 1'b0;
         r_invalid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_borrow <= ~carry_in;
                  r_cnt    <= 2'd0;
                  r_work   <= 16'h0000;
                  r_inv    <= 1'b0;
                  r_state  <= S_RUN;
               end else begin
                  r_state  <= S_IDLE;
               end
            end
            S_RUN: begin
               r_work   <= w_work_nxt;
               r_borrow <= w_brw_nxt;
               r_inv    <= w_inv_nxt;
               r_cnt    <= r_cnt + 2'd1;
               if (r_cnt == 2'd3) begin
                  r_state   <= S_DONE;
                  r_result  <= w_work_nxt;
                  r_cout    <= ~w_brw_nxt;
                  r_zero    <= (w_work_nxt == 16'h0000);
                  r_invalid <= w_inv_nxt;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = (r_state == S_RUN);
   assign done      = (r_state == S_DONE);
   assign result    = r_result;
   assign carry_out = r_cout;
   assign zero      = r_zero;
   assign invalid   = r_invalid;

endmodule

// File: tb/tb_alu_dsub_serial.sv
// Randomised self-checking bench for alu_dsub_serial against a per-digit decimal model.
module tb_alu_dsub_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        carry_in;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        carry_out;
   logic        zero;
   logic        invalid;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_dsub_serial dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .carry_in(carry_in),
      .busy(busy), .done(done), .result(result), .carry_out(carry_out),
      .zero(zero), .invalid(invalid)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Decimal subtraction digit by digit, as plain integer arithmetic
   task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mcin,
                        output logic [15:0] mres, output logic mcout,
                        output logic mzero, output logic minv);
      int br;
      int d;
      int ai;
      int bi;
      br   = mcin ? 0 : 1;
      mres = 16'h0000;
      minv = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ai = (ma >> (4 * i)) & 15;
         bi = (mb >> (4 * i)) & 15;
         if (ai > 9 || bi > 9) minv = 1'b1;
         d = ai - bi - br;
         if (d < 0) begin
            d  = d + 10;
            br = 1;
         end else begin
            br = 0;
         end
         mres = mres | (16'(d & 15) << (4 * i));
      end
      mcout = (br == 0);
      mzero = (mres == 16'h0000);
   endtask

   function automatic logic [15:0] rnd_bcd();
      logic [15:0] v;
      v = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         if ($urandom_range(0, 7) == 0) v = v | (16'($urandom_range(10, 15)) << (4 * i));
         else                           v = v | (16'($urandom_range(0, 9)) << (4 * i));
      end
      return v;
   endfunction

   // Launch one operation, scramble inputs during RUN, then check latency and outputs
   task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc);
      logic [15:0] er;
      logic        ec, ez, ei;
      int          n;
      model(ta, tb_v, tc, er, ec, ez, ei);
      @(negedge clk);
      a = ta; b = tb_v; carry_in = tc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 10) begin
         if (busy) n++;
         a = 16'($urandom); b = 16'($urandom); carry_in = 1'($urandom);
         @(negedge clk);
      end
      chk({tag, ".busy_cycles"}, n, 4);
      chk({tag, ".done"}, {busy, done}, 2'b01);
      chk({tag, ".result"}, result, er);
      chk({tag, ".carry_out"}, carry_out, ec);
      chk({tag, ".zero"}, zero, ez);
      chk({tag, ".invalid"}, invalid, ei);
   endtask

   initial begin
      logic [15:0] er;
      logic        ec, ez, ei;
      int          k;
      int          seen_done;
      rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; carry_in = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.result", result, 0);
      chk("rst.flags", {carry_out, zero, invalid}, 3'b000);
      rst = 1'b0;

      do_op("d030", 16'h1234, 16'h0234, 1'b1);
      chk("d030.lit", {result, carry_out, zero, invalid}, {16'h1000, 3'b100});
      do_op("d031", 16'h0000, 16'h0001, 1'b1);
      chk("d031.lit", {result, carry_out, zero}, {16'h9999, 2'b00});
      do_op("d032", 16'h5000, 16'h4999, 1'b0);
      chk("d032.lit", {result, carry_out, zero}, {16'h0000, 2'b11});
      do_op("d033", 16'h00A0, 16'h0000, 1'b1);
      chk("d033.lit", {result, invalid, carry_out}, {16'h00A0, 2'b11});

      // Back-to-back: ignored start mid-RUN, restart from the DONE cycle
      @(negedge clk);
      a = 16'h9999; b = 16'h0001; carry_in = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); a = 16'h1111; b = 16'h1111; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("b2b.done1", done, 1);
      chk("b2b.res1", result, 16'h9998);
      a = 16'h0010; b = 16'h0009; carry_in = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      k = 1;
      while (!done && k < 12) begin
         if (k == 2) chk("b2b.hold", result, 16'h9998);
         @(negedge clk);
         k++;
      end
      chk("b2b.period", k, 5);
      chk("b2b.res2", result, 16'h0001);

      // Reset during the second RUN cycle aborts without a done pulse
      @(negedge clk);
      a = 16'h4321; b = 16'h1234; carry_in = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("abort.outs", {busy, done, result, carry_out, zero, invalid}, 21'h0);
      seen_done = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      chk("abort.no_done", seen_done, 0);
      do_op("after_rst", 16'h4321, 16'h1234, 1'b1);
      chk("after_rst.lit", result, 16'h3087);

      for (int i = 0; i < 40; i++) begin
         do_op("rand", rnd_bcd(), rnd_bcd(), 1'($urandom));
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      model(16'h0000, 16'h0000, 1'b0, er, ec, ez, ei);
      do_op("zero_borrow", 16'h0000, 16'h0000, 1'b0);
      chk("zero_borrow.lit", {result, carry_out}, {er, ec});

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
